morse_key_classifier: RTL and testbench

- Parametrised Morse key front end. Samples the active-low key input on a tick strobe and times each press.
- Classifies each press as dot, line or error, and times each released interval to flag character and word gaps.
- Sits between the key input and the symbol shift/decode datapath.
- Drives one-cycle load strobes that the datapath consumes directly.

---
 rtl/morse_key_classifier_pkg.sv | 24 ++
 rtl/morse_key_classifier_if.sv | 22 ++
 rtl/morse_key_debouncer.sv | 46 ++++
 rtl/morse_key_classifier.sv | 140 ++++++++++++++
 tb/tb_morse_key_classifier.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/morse_key_classifier_pkg.sv
// morse_pkg: shared types and constants for the Morse key classifier.
//   state_t     - classifier FSM states
//   KEY_PRESSED - level of the key input when the key is down
//   strobe_t    - bundle of one-cycle symbol/gap load strobes
package morse_pkg;

  typedef enum logic [1:0] {
    S_WAIT_REL,
    S_IDLE,
    S_PRESS,
    S_GAP
  } state_t;

  localparam logic KEY_PRESSED = 1'b0;

  typedef struct packed {
    logic dot;
    logic line;
    logic err;
    logic char_gap;
    logic word_gap;
  } strobe_t;

endpackage

// File: rtl/morse_key_classifier_if.sv
// morse_key_if: strobe bundle from the key classifier to the symbol
// shift/decode datapath.
//   ld_dot, ld_line, ld_err      - one-cycle symbol classification strobes
//   ld_char_gap, ld_word_gap     - one-cycle gap strobes
//   busy                         - classifier is timing a press or a gap
// modport master: classifier side (drives). modport slave: datapath side.
interface morse_key_if;
  logic ld_dot;
  logic ld_line;
  logic ld_err;
  logic ld_char_gap;
  logic ld_word_gap;
  logic busy;

  modport master (
    output ld_dot, ld_line, ld_err, ld_char_gap, ld_word_gap, busy
  );

  modport slave (
    input ld_dot, ld_line, ld_err, ld_char_gap, ld_word_gap, busy
  );
endinterface

// File: rtl/morse_key_debouncer.sv
// morse_key_debouncer: 2-flop synchroniser followed by a tick-sampled
// stability filter. Built only when MORSE_KEY_DEBOUNCE_EN is defined.
//   clock, resetn - clock and synchronous active-low reset
//   tick_en       - sample strobe for the stability filter
//   key_raw       - asynchronous key input (active low)
//   key_filt      - filtered key, changes after DB_TICKS equal samples
module morse_key_debouncer
  import morse_pkg::*;
#(
  parameter int DB_TICKS = 3
) (
  input  logic clock,
  input  logic resetn,
  input  logic tick_en,
  input  logic key_raw,
  output logic key_filt
);

  localparam int RUN_W = (DB_TICKS < 2) ? 1 : $clog2(DB_TICKS + 1);
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(DB_TICKS - 1);

  logic [1:0]       sync;
  logic [RUN_W-1:0] run;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      sync     <= {2{~KEY_PRESSED}};
      key_filt <= ~KEY_PRESSED;
      run      <= '0;
    end else begin
      sync <= {sync[0], key_raw};
      if (tick_en) begin
        // run counts consecutive samples that disagree with key_filt
        if (sync[1] == key_filt) begin
          run <= '0;
        end else if (run == RUN_LAST) begin
          key_filt <= sync[1];
          run      <= '0;
        end else begin
          run <= run + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/morse_key_classifier.sv
// morse_key_classifier: times key presses and released intervals on a tick
// strobe and emits registered one-cycle strobes for dot, line, error,
// character gap and word gap.
//   clock, resetn - clock and synchronous active-low reset
//   tick_en       - sample strobe; FSM and counter advance only when high
//   input_in      - key input, active low
//   sym           - strobe bundle to the datapath (morse_key_if.master)
// Optional: define MORSE_KEY_DEBOUNCE_EN to insert the synchroniser and
// stability filter (morse_key_debouncer) in front of the FSM.
//
// state      | meaning
// S_WAIT_REL | key must be seen released before anything is timed
// S_IDLE     | key up, no gap being timed
// S_PRESS    | key down, cnt = ticks pressed (saturates at LINE_MAX+1)
// S_GAP      | key up after a symbol, cnt = released ticks so far
module morse_key_classifier
  import morse_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int DOT_MAX  = 2,
  parameter int LINE_MAX = 6,
  parameter int CHAR_GAP = 3,
  parameter int WORD_GAP = 7,
  parameter int DB_TICKS = 3
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        tick_en,
  input  logic        input_in,
  morse_key_if.master sym
);

  localparam logic [CNT_W-1:0] DOT_C   = CNT_W'(DOT_MAX);
  localparam logic [CNT_W-1:0] LINE_C  = CNT_W'(LINE_MAX);
  localparam logic [CNT_W-1:0] SAT_C   = CNT_W'(LINE_MAX + 1);
  localparam logic [CNT_W-1:0] CHAR_C  = CNT_W'(CHAR_GAP);
  localparam logic [CNT_W-1:0] WORD_C  = CNT_W'(WORD_GAP);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  generate
    if (DOT_MAX < 1 || LINE_MAX <= DOT_MAX || LINE_MAX >= (1 << CNT_W) - 1 ||
        WORD_GAP <= CHAR_GAP || WORD_GAP >= (1 << CNT_W) - 1 || DB_TICKS < 1)
    begin : g_bad_params
      $error("morse_key_classifier: illegal parameter combination");
    end
  endgenerate

  logic key_s;

`ifdef MORSE_KEY_DEBOUNCE_EN
  morse_key_debouncer #(
    .DB_TICKS (DB_TICKS)
  ) u_debouncer (
    .clock    (clock),
    .resetn   (resetn),
    .tick_en  (tick_en),
    .key_raw  (input_in),
    .key_filt (key_s)
  );
`else
  assign key_s = input_in;
`endif

  logic pressed;
  assign pressed = (key_s == KEY_PRESSED);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  strobe_t          str, str_n;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state <= S_WAIT_REL;
      cnt   <= '0;
      str   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      str   <= str_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    str_n   = '0;
    if (tick_en) begin
      case (state)
        S_WAIT_REL: begin
          if (!pressed) state_n = S_IDLE;
        end
        S_IDLE: begin
          if (pressed) begin
            cnt_n   = ONE_C;
            state_n = S_PRESS;
          end
        end
        S_PRESS: begin
          if (pressed) begin
            if (cnt < SAT_C) cnt_n = cnt + 1'b1;
          end else if (cnt <= DOT_C) begin
            str_n.dot = 1'b1;
            cnt_n     = ONE_C;
            state_n   = S_GAP;
          end else if (cnt <= LINE_C) begin
            str_n.line = 1'b1;
            cnt_n      = ONE_C;
            state_n    = S_GAP;
          end else begin
            str_n.err = 1'b1;
            state_n   = S_IDLE;
          end
        end
        S_GAP: begin
          // a press abandons the gap even on a threshold tick
          if (pressed) begin
            cnt_n   = ONE_C;
            state_n = S_PRESS;
          end else begin
            cnt_n = cnt + 1'b1;
            if (cnt_n == CHAR_C) str_n.char_gap = 1'b1;
            if (cnt_n == WORD_C) begin
              str_n.word_gap = 1'b1;
              state_n        = S_IDLE;
            end
          end
        end
        default: state_n = S_WAIT_REL;
      endcase
    end
  end

  assign sym.ld_dot      = str.dot;
  assign sym.ld_line     = str.line;
  assign sym.ld_err      = str.err;
  assign sym.ld_char_gap = str.char_gap;
  assign sym.ld_word_gap = str.word_gap;
  assign sym.busy        = (state == S_PRESS) || (state == S_GAP);

endmodule

// File: tb/tb_morse_key_classifier.sv
module tb_morse_key_classifier;

  localparam int DOT_MAX  = 2;
  localparam int LINE_MAX = 6;
  localparam int CHAR_GAP = 3;
  localparam int WORD_GAP = 7;

  logic clock = 1'b0;
  logic resetn;
  logic tick_en;
  logic input_in;

  morse_key_if sym_if ();

  morse_key_classifier #(
    .CNT_W    (8),
    .DOT_MAX  (DOT_MAX),
    .LINE_MAX (LINE_MAX),
    .CHAR_GAP (CHAR_GAP),
    .WORD_GAP (WORD_GAP),
    .DB_TICKS (3)
  ) dut (
    .clock    (clock),
    .resetn   (resetn),
    .tick_en  (tick_en),
    .input_in (input_in),
    .sym      (sym_if)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;
  int dots_seen = 0;

  // Run-length reference: track the current run of equal key samples.
  bit blocked;       // waiting for a first released sample after reset
  bit run_pressed;
  int run_len;
  bit armed;         // released run that follows a valid symbol
  logic [5:0] exp_v; // {busy, dot, line, err, char_gap, word_gap}

  task automatic chk(input string tag, input logic [5:0] obs, input logic [5:0] req);
    n_cmp++;
    if (obs !== req) begin
      n_err++;
      $display("FAIL %s @%0t: got %b want %b (busy,dot,line,err,cg,wg)", tag, $time, obs, req);
    end
  endtask

  task automatic model(input logic key, input logic tk, input logic rn);
    logic d, l, e, c, w;
    d = 0; l = 0; e = 0; c = 0; w = 0;
    if (!rn) begin
      blocked = 1; armed = 0; run_pressed = 0; run_len = 0;
    end else if (tk) begin
      if (blocked) begin
        if (key) begin
          blocked = 0; run_pressed = 0; run_len = 1; armed = 0;
        end
      end else if (!key && run_pressed) begin
        run_len++;
      end else if (key && !run_pressed) begin
        run_len++;
        if (armed && run_len == CHAR_GAP) c = 1;
        if (armed && run_len == WORD_GAP) begin w = 1; armed = 0; end
      end else if (!key) begin
        run_pressed = 1; run_len = 1; armed = 0;
      end else begin
        if (run_len <= DOT_MAX) d = 1;
        else if (run_len <= LINE_MAX) l = 1;
        else e = 1;
        armed = !e; run_pressed = 0; run_len = 1;
      end
    end
    exp_v = {(!blocked && (run_pressed || armed)), d, l, e, c, w};
  endtask

  task automatic step(input logic key, input logic tk, input logic rn);
    logic [5:0] obs;
    input_in = key; tick_en = tk; resetn = rn;
    @(posedge clock);
    model(key, tk, rn);
    #1;
    obs = {sym_if.busy, sym_if.ld_dot, sym_if.ld_line, sym_if.ld_err,
           sym_if.ld_char_gap, sym_if.ld_word_gap};
    if (sym_if.ld_dot) dots_seen++;
`ifdef MORSE_KEY_DEBOUNCE_EN
    chk("db_quiet", {1'b0, obs[4:0]}, 6'b0);
`else
    chk("outs", obs, exp_v);
`endif
  endtask

  // hold key level for n ticks; mode 1 = random tick_en, rst = random resets
  task automatic hold(input logic key, input int n, input int mode, input bit rst);
    int k;
    logic tk, rn;
    k = 0;
    while (k < n) begin
      tk = (mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      rn = rst ? ($urandom_range(0, 79) != 0) : 1'b1;
      step(key, tk, rn);
      if (tk) k++;
    end
  endtask

  task automatic symbol(input int p, input int g);
    hold(1'b0, p, 0, 0);
    hold(1'b1, g, 0, 0);
  endtask

  initial begin
    input_in = 1'b1; tick_en = 1'b1; resetn = 1'b0;
    blocked = 1; armed = 0; run_pressed = 0; run_len = 0; exp_v = '0;
    repeat (3) step(1'b1, 1'b1, 1'b0);
    repeat (2) step(1'b1, 1'b1, 1'b1);

`ifndef MORSE_KEY_DEBOUNCE_EN
    dots_seen = 0;
    symbol(2, 10);
    chk("dot_count", 6'(dots_seen), 6'd1);
    symbol(3, 10);
    symbol(6, 10);
    symbol(7, 10);
    // dot, then press where the gap count would reach CHAR_GAP
    symbol(1, CHAR_GAP - 1);
    symbol(2, 10);
    // reset during the 2nd tick of a press, key held on, then released
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    hold(1'b0, 5, 0, 0);
    hold(1'b1, 3, 0, 0);
    dots_seen = 0;
    symbol(1, 10);
    chk("dot_after_rst", 6'(dots_seen), 6'd1);
    // key low only between sparse ticks
    step(1'b1, 1'b1, 1'b1);
    repeat (3) step(1'b0, 1'b0, 1'b1);
    repeat (4) step(1'b1, (1'b1), 1'b1);
    // randomized symbols, tick pacing and occasional resets
    for (int i = 0; i < 60; i++) begin
      hold(1'b0, $urandom_range(1, LINE_MAX + 3), $urandom_range(0, 1), (i > 30));
      hold(1'b1, $urandom_range(1, WORD_GAP + 3), $urandom_range(0, 1), (i > 30));
    end
    hold(1'b1, 10, 0, 0);
`else
    // glitches between sparse ticks and a 2-tick glitch must be ignored
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 1'b1);
      repeat (3) step(1'b0, 1'b0, 1'b1);
      repeat (3) step(1'b1, 1'b0, 1'b1);
    end
    repeat (4) step(1'b1, 1'b1, 1'b1);
    repeat (2) step(1'b0, 1'b1, 1'b1);
    repeat (12) step(1'b1, 1'b1, 1'b1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
